// File: rtl/motor_ramp_controller_if.sv
// Command handshake between the motion host and motor_ramp_controller.
interface motor_ramp_controller_if #(
  parameter int SPEED_W = 13
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_enable;
  logic               cmd_direction;
  logic [SPEED_W-1:0] cmd_speed;

  modport master (output cmd_valid, cmd_enable, cmd_direction, cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, cmd_enable, cmd_direction, cmd_speed, output cmd_ready);
endinterface

// File: rtl/motor_ramp_controller.sv
// Slews the PWM driver speed toward the commanded target; reversals go ramp-down, dead-time, ramp-up.
// Optional SPEED_LIMIT_EN: clamp commands to MAX_SPEED and pulse limit_hit when a command was clamped.
module motor_ramp_controller #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int PWM_FREQ     = 20_000,
  parameter int PERIOD       = CLK_FREQ / PWM_FREQ,
  parameter int SPEED_W      = $clog2(PERIOD),
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 5,
  parameter int DEADTIME_CYC = 10000,
  parameter int MAX_SPEED    = 4000
) (
  input  logic                     clk,
  input  logic                     rst,
  motor_ramp_controller_if.slave   cmd,
  input  logic                     estop,
  output logic                     enable,
  output logic                     direction,
  output logic [SPEED_W-1:0]       speed,
  output logic                     busy,
  output logic                     at_target
`ifdef SPEED_LIMIT_EN
  ,
  output logic                     limit_hit
`endif
);

`ifdef SPEED_LIMIT_EN
  localparam int LIMIT = MAX_SPEED;
`else
  localparam int LIMIT = PERIOD + 0 * MAX_SPEED;
`endif
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = $clog2(DEADTIME_CYC + 1);
  localparam logic [SPEED_W-1:0] LIM_S   = SPEED_W'(LIMIT);
  localparam logic [SPEED_W:0]   STEP    = (SPEED_W+1)'(RAMP_STEP);
  localparam logic [PW-1:0]      PRE_MAX = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]      DEAD_LD = DW'(DEADTIME_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} state_t;

  state_t             state, nxt_state;
  logic               tgt_en, tgt_dir;
  logic [SPEED_W-1:0] tgt_spd;
  logic [PW-1:0]      pre;
  logic [DW-1:0]      dead_cnt, nxt_dcnt;
  logic               nxt_en, nxt_dir;
  logic [SPEED_W-1:0] nxt_spd;
  logic               nxt_tgt_en, nxt_tgt_dir;
  logic [SPEED_W-1:0] nxt_tgt_spd, cmd_clamped, eff, nxt_eff;
  logic               tick, accept, clamp_hit;

  // Saturating slew in SPEED_W+1 bits so neither overshoot nor wrap is possible.
  function automatic logic [SPEED_W-1:0] ramp(input logic [SPEED_W-1:0] cur,
                                               input logic [SPEED_W-1:0] tgt);
    logic [SPEED_W:0] c, t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c)      ramp = (t - c <= STEP) ? tgt : SPEED_W'(c + STEP);
    else if (c > t) ramp = (c - t <= STEP) ? tgt : SPEED_W'(c - STEP);
    else            ramp = cur;
  endfunction

  assign cmd.cmd_ready = !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign tick          = (pre == PRE_MAX);
  assign clamp_hit     = (cmd.cmd_speed > LIM_S);
  assign cmd_clamped   = clamp_hit ? LIM_S : cmd.cmd_speed;

  // A pending reversal shows up as a zero target so RUN decelerates first.
  assign eff = (!tgt_en || (tgt_dir != direction)) ? '0 : tgt_spd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre <= '0;
    else      pre <= tick ? '0 : pre + 1'b1;
  end

  always_comb begin
    nxt_tgt_en  = tgt_en;
    nxt_tgt_dir = tgt_dir;
    nxt_tgt_spd = tgt_spd;
    if (estop) begin
      nxt_tgt_en = 1'b0;
    end else if (accept) begin
      nxt_tgt_en  = cmd.cmd_enable;
      nxt_tgt_dir = cmd.cmd_direction;
      nxt_tgt_spd = cmd_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_en  <= 1'b0;
      tgt_dir <= 1'b0;
      tgt_spd <= '0;
    end else begin
      tgt_en  <= nxt_tgt_en;
      tgt_dir <= nxt_tgt_dir;
      tgt_spd <= nxt_tgt_spd;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_en    = enable;
    nxt_dir   = direction;
    nxt_spd   = speed;
    nxt_dcnt  = dead_cnt;
    if (estop) begin
      nxt_state = DEAD;
      nxt_en    = 1'b0;
      nxt_spd   = '0;
      nxt_dcnt  = DEAD_LD;
    end else begin
      case (state)
        IDLE: begin
          nxt_en  = 1'b0;
          nxt_spd = '0;
          if (tgt_en && tgt_spd != '0) begin
            nxt_state = RUN;
            nxt_dir   = tgt_dir;
            nxt_en    = 1'b1;
          end
        end
        RUN: begin
          if (eff == '0) nxt_state = DECEL;
          if (tick)      nxt_spd   = ramp(speed, eff);
        end
        DECEL: begin
          if (eff != '0) begin
            nxt_state = RUN;
            if (tick) nxt_spd = ramp(speed, eff);
          end else if (speed == '0) begin
            nxt_state = DEAD;
            nxt_en    = 1'b0;
            nxt_dcnt  = DEAD_LD;
          end else if (tick) begin
            nxt_spd = ramp(speed, '0);
          end
        end
        DEAD: begin
          nxt_en  = 1'b0;
          nxt_spd = '0;
          if (dead_cnt == '0) nxt_state = IDLE;
          else                nxt_dcnt  = dead_cnt - DW'(1);
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Status flags are evaluated against next-cycle state so they stay aligned with it.
  assign nxt_eff = (!nxt_tgt_en || (nxt_tgt_dir != nxt_dir)) ? '0 : nxt_tgt_spd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      enable    <= 1'b0;
      direction <= 1'b0;
      speed     <= '0;
      dead_cnt  <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      state     <= nxt_state;
      enable    <= nxt_en;
      direction <= nxt_dir;
      speed     <= nxt_spd;
      dead_cnt  <= nxt_dcnt;
      busy      <= (nxt_state != IDLE);
      at_target <= (nxt_state == RUN) && (nxt_spd == nxt_eff);
    end
  end

`ifdef SPEED_LIMIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) limit_hit <= 1'b0;
    else      limit_hit <= accept && clamp_hit;
  end
`endif

endmodule
